l1_mem_port_arbiter: RTL

- Shares the single L2/external-memory command port and its read/write data buffers between two L1 cache controllers: requester 0 (instruction cache) and requester 1 (data cache).
- Grants the port for a whole miss-service sequence: read-block request, optional dirty-line writeback fill and command, then read-buffer drain.
- Sits between the two L1 controllers and the L2 controller/buffer pair.
- Round-robin on contention, with word-level transaction tracking so the grant is never released mid-transfer.

---
 rtl/l1_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/l1_mem_port_arbiter.sv
// Round-robin owner of the shared L2 command port and buffers for the I- and D-cache controllers.
// Optional per-requester wait/grant statistics are enabled with `define L1_ARB_STATS_EN.
`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 30
`endif
`ifndef BW_BLOCK
`define BW_BLOCK 2
`endif

module l1_mem_port_arbiter #(
    parameter int BW_ADDR   = `BW_WORD_ADDR,
    parameter int BW_BLOCK  = `BW_BLOCK,
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [1:0]           lock_i,
    input  logic [1:0]           req_i,
    input  logic [1:0]           req_block_i,
    input  logic [1:0]           rw_i,
    input  logic [2*BW_ADDR-1:0] addr_i,
    output logic [1:0]           ready_o,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic                 mem_req_block_o,
    output logic                 mem_rw_o,
    output logic [BW_ADDR-1:0]   mem_addr_o,
    input  logic                 rbuf_ready_i,
    output logic [1:0]           rbuf_ready_o,
    input  logic [1:0]           rbuf_ack_i,
    output logic                 rbuf_ack_o,
    input  logic                 wbuf_ready_i,
    output logic [1:0]           wbuf_ready_o,
    input  logic [1:0]           wbuf_ack_i,
    input  logic [63:0]          wbuf_data_i,
    output logic                 wbuf_ack_o,
    output logic [31:0]          wbuf_data_o,
    output logic [1:0]           grant_o,
`ifdef L1_ARB_STATS_EN
    output logic [63:0]          wait_cycles_o,
    output logic [63:0]          grants_o,
`endif
    output logic                 err_o
);

    localparam int CW          = BW_BLOCK + 1;
    localparam int SW          = BW_BLOCK + 3;
    localparam int BLOCK_WORDS = 1 << BW_BLOCK;
    localparam logic signed [SW-1:0] MAX_PEND = SW'(BLOCK_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_RELEASE} state_t;

    state_t state, state_next;
    logic owner, prio;
    logic grant_fire, grant_sel;
    logic owned, release_ok, protocol_viol;
    logic own_lock, own_req, own_block, own_rw, own_rack, own_wack;
    logic [BW_ADDR-1:0] own_addr;
    logic [31:0] own_data;
    logic [CW-1:0] rd_pend, wr_pend, rd_next, wr_next;
    logic signed [SW-1:0] burst, rd_sum, wr_sum;
    logic cnt_err;

    assign owned = (state == ST_OWNED);

    always_comb begin
        own_lock  = owner ? lock_i[1]      : lock_i[0];
        own_req   = owner ? req_i[1]       : req_i[0];
        own_block = owner ? req_block_i[1] : req_block_i[0];
        own_rw    = owner ? rw_i[1]        : rw_i[0];
        own_rack  = owner ? rbuf_ack_i[1]  : rbuf_ack_i[0];
        own_wack  = owner ? wbuf_ack_i[1]  : wbuf_ack_i[0];
        own_addr  = owner ? addr_i[2*BW_ADDR-1:BW_ADDR] : addr_i[BW_ADDR-1:0];
        own_data  = owner ? wbuf_data_i[63:32] : wbuf_data_i[31:0];
    end

    assign release_ok    = !own_lock && (rd_pend == '0) && (wr_pend == '0) && !own_req;
    assign protocol_viol = !owned && ((|req_i) || (|rbuf_ack_i) || (|wbuf_ack_i));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_fire = 1'b0;
        grant_sel  = prio;
        case (state)
            ST_IDLE: begin
                if (|lock_i) begin
                    grant_fire = 1'b1;
                    grant_sel  = (&lock_i) ? prio : lock_i[1];
                    state_next = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (release_ok) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_o         = '0;
        ready_o         = '0;
        rbuf_ready_o    = '0;
        wbuf_ready_o    = '0;
        mem_req_o       = 1'b0;
        mem_req_block_o = 1'b0;
        mem_rw_o        = 1'b0;
        mem_addr_o      = '0;
        rbuf_ack_o      = 1'b0;
        wbuf_ack_o      = 1'b0;
        wbuf_data_o     = '0;
        if (owned) begin
            grant_o[owner]      = 1'b1;
            ready_o[owner]      = mem_ready_i;
            rbuf_ready_o[owner] = rbuf_ready_i;
            wbuf_ready_o[owner] = wbuf_ready_i;
            mem_req_o           = own_req;
            mem_req_block_o     = own_block;
            mem_rw_o            = own_rw;
            mem_addr_o          = own_addr;
            rbuf_ack_o          = own_rack;
            wbuf_ack_o          = own_wack;
            wbuf_data_o         = own_data;
        end
    end

    // Net same-cycle update of both outstanding-word counters, clamped to [0, block size].
    always_comb begin
        cnt_err = 1'b0;
        burst   = own_block ? MAX_PEND : SW'(1);
        rd_sum  = $signed({2'b00, rd_pend}) + ((own_req && !own_rw) ? burst : '0)
                  - $signed(SW'(own_rack));
        wr_sum  = $signed({2'b00, wr_pend}) + $signed(SW'(own_wack))
                  - ((own_req && own_rw) ? burst : '0);
        if (rd_sum[SW-1]) begin
            rd_next = '0;
            cnt_err = 1'b1;
        end else if (rd_sum > MAX_PEND) begin
            rd_next = CW'(BLOCK_WORDS);
            cnt_err = 1'b1;
        end else begin
            rd_next = rd_sum[CW-1:0];
        end
        if (wr_sum[SW-1]) begin
            wr_next = '0;
            cnt_err = 1'b1;
        end else if (wr_sum > MAX_PEND) begin
            wr_next = CW'(BLOCK_WORDS);
            cnt_err = 1'b1;
        end else begin
            wr_next = wr_sum[CW-1:0];
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            owner   <= 1'b0;
            prio    <= INIT_PRIO;
            rd_pend <= '0;
            wr_pend <= '0;
            err_o   <= 1'b0;
        end else begin
            if (grant_fire) begin
                owner <= grant_sel;
                prio  <= ~grant_sel;
            end
            if (owned) begin
                rd_pend <= rd_next;
                wr_pend <= wr_next;
            end
            err_o <= err_o | protocol_viol | (owned & cnt_err);
        end
    end

`ifdef L1_ARB_STATS_EN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wait_cycles_o <= '0;
            grants_o      <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (lock_i[n] && !grant_o[n]) begin
                    wait_cycles_o[n*32 +: 32] <= wait_cycles_o[n*32 +: 32] + 32'd1;
                end
                if (grant_fire && (grant_sel == n[0])) begin
                    grants_o[n*32 +: 32] <= grants_o[n*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
